bottling_input_frontend: RTL and testbench
==========================================

# bottling_input_frontend

Conditions the panel's raw push-buttons and the pill sensor, and holds the operator-edited bottle and pill settings. It feeds the bottling core directly: one-cycle `flip_working`, `shift_selection` and `pill_pulse` strobes, the `display_flicker` square wave, and the binary `bottle_setting`/`pill_setting` values. It consumes the core's `working` and `selection` to decide which setting digit the up-key edits.

## Interface
- `DEBOUNCE_CYCLES`, 20000: consecutive stable synchronized samples needed to accept a key level change.
- `PILL_DEBOUNCE_CYCLES`, 200: the same for the pill sensor.
- `REPEAT_DELAY`, 10000000: cycles the up-key is held after acceptance before auto-repeat starts.
- `REPEAT_PERIOD`, 2500000: cycles between auto-repeat increments.
- `FLICKER_HALF`, 5000000: cycles per half-period of `display_flicker`.
- `DEFAULT_BOTTLE`, 10: reset value of the bottle setting; 1..99.
- `DEFAULT_PILL`, 5: reset value of the pill setting; 1..99.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `key_start_raw`  in  1  asynchronous start/stop button; active high.
- `key_select_raw`  in  1  asynchronous select button; active high.
- `key_up_raw`  in  1  asynchronous increment button; active high.
- `pill_sensor_raw`  in  1  asynchronous pill-drop sensor; active high.
- `working`  in  1  core run state.
- `selection`  in  5  one-hot field select from the core; 0 means none.
- `flip_working`  out  1  one-cycle strobe on an accepted start press.
- `shift_selection`  out  1  one-cycle strobe on an accepted select press.
- `pill_pulse`  out  1  one-cycle strobe on an accepted sensor rising edge.
- `display_flicker`  out  1  free-running square wave.
- `bottle_setting`  out  8  binary bottle count, 1..99.
- `pill_setting`  out  8  binary pills per bottle, 1..99.

## Operation
- **Synchronizer.** Each raw input passes through a 2-flop synchronizer that resets to 0.
- **Debouncer.** There is one per input, each with a `stable` register and a mismatch counter.
  - The counter increments while the synchronized value differs from `stable`.
  - The counter clears on any cycle where the two match.
  - When the counter reaches the threshold, `stable` takes the new value and the counter clears.
- **Strobes.** Each strobe is registered.
  - It is asserted exactly one cycle after `stable` goes 0 -> 1.
  - Release (1 -> 0) produces no strobe.
- **Settings storage.** Settings are held internally as BCD digit pairs: `b_tens`, `b_ones`, `p_tens`, `p_ones`.
  - Each output equals `tens*10 + ones`, registered.
- **Field mapping.**
  - `selection[1]`: bottle ones digit.
  - `selection[2]`: bottle tens digit.
  - `selection[3]`: pill ones digit.
  - `selection[4]`: pill tens digit.
  - `selection[0]` and `selection == 0`: no field selected.
- **Increment event.** An increment event is an accepted up-key press or an auto-repeat tick. It acts only when `working == 0` and one of `selection[4:1]` is set.
  - The selected digit steps 9 -> 0 without carry into the other digit.
  - If the resulting pair is 00, the ones digit is forced to 1.
- **Auto-repeat counter.** This counter runs while the debounced up-key is 1 and clears when the key is released.
  - First tick: `REPEAT_DELAY` cycles after acceptance.
  - Further ticks: every `REPEAT_PERIOD` cycles after that.
  - Ticks that arrive while `working == 1` are discarded, but the counter keeps running.
- **Flicker.** A counter toggles `display_flicker` every `FLICKER_HALF` cycles.

## Timing
- **Reset values.**
  - Strobes: 0.
  - `display_flicker`: 0.
  - Settings: `DEFAULT_BOTTLE` and `DEFAULT_PILL`.
  - All counters, synchronizers and `stable` registers: 0.
- **Strobe latency.** Take cycle 0 as the first `clk` edge that samples a raw high which then stays high. `stable` rises at the edge of cycle 1+N, where N is the relevant debounce threshold. The strobe is high during the cycle following edge 2+N, for exactly 1 cycle.
- **Bounce rejection.** A raw glitch shorter than N cycles produces no strobe and leaves `stable` unchanged.
- **Settings latency.** A setting output changes on the second edge after the increment event: one cycle to update the digit, one cycle to form the binary output.
- **Selection sampling.** `selection` and `working` are sampled in the same cycle as the increment event. A change in that same cycle therefore takes effect immediately.
- **Simultaneous events.**
  - Start and select accepted together: both strobes assert in the same cycle.
  - An up-key tick coinciding with `flip_working`: uses the pre-flip `working`.
- **Reset mid-operation.** `reset` in any cycle restores all reset values at the next edge.
  - A press in progress is lost.
  - Edits since the previous reset are discarded.

## Test plan
- **Debounce pulse.** Run with N=4. Drive `key_start_raw` high from cycle 0 and hold it. Expect exactly one `flip_working` pulse, in the cycle following edge 6. Then release and expect no pulse.
- **Glitch rejection.** Run with N=4. Drive `key_select_raw` high for 3 cycles, low for 1, then repeat that pattern 5 times. Expect no `shift_selection` pulse.
- **Digit wrap.** With `selection = 5'b00010`, `working = 0` and reset settings (bottle 10), give one up press: expect bottle = 11. Preload bottle to 19 and press: expect 10. Preload bottle to 90, select the tens digit (`5'b00100`) and press: expect 1 (00 forced to 01).
- **Auto-repeat.** Run with `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=5, `selection = 5'b01000`, pill = 5. Hold up for 40 cycles past acceptance. Expect pill values 6, 7, 8, 9, 0 -> 1, i.e. increments at offsets 0, 20, 25, 30, 35.
- **Edit lockout.** With `working = 1`, press up with `selection = 5'b00010`. Expect `bottle_setting` unchanged.
- **Reset and flicker.** Run with `FLICKER_HALF`=3. Expect `display_flicker` to toggle every 3 cycles. Assert `reset` mid-repeat. The next cycle must show flicker = 0, settings = 10/5 and no strobes.

Source files
------------

// File: rtl/bottling_input_frontend.sv
// Panel input conditioning for the bottling core: synchronizes and debounces the
// keys and pill sensor, keeps the BCD bottle/pill settings and drives the display flicker.
module bottling_input_frontend #(
  parameter int DEBOUNCE_CYCLES      = 20000,
  parameter int PILL_DEBOUNCE_CYCLES = 200,
  parameter int REPEAT_DELAY         = 10000000,
  parameter int REPEAT_PERIOD        = 2500000,
  parameter int FLICKER_HALF         = 5000000,
  parameter int DEFAULT_BOTTLE       = 10,
  parameter int DEFAULT_PILL         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_raw,
  input  logic       key_select_raw,
  input  logic       key_up_raw,
  input  logic       pill_sensor_raw,
  input  logic       working,
  input  logic [4:0] selection,
  output logic       flip_working,
  output logic       shift_selection,
  output logic       pill_pulse,
  output logic       display_flicker,
  output logic [7:0] bottle_setting,
  output logic [7:0] pill_setting
);

  localparam int DEB_MAX = (DEBOUNCE_CYCLES > PILL_DEBOUNCE_CYCLES) ?
                           DEBOUNCE_CYCLES : PILL_DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(DEB_MAX + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam int FW      = $clog2(FLICKER_HALF + 1);

  localparam logic [3:0] B_TENS_RST = 4'(DEFAULT_BOTTLE / 10);
  localparam logic [3:0] B_ONES_RST = 4'(DEFAULT_BOTTLE % 10);
  localparam logic [3:0] P_TENS_RST = 4'(DEFAULT_PILL / 10);
  localparam logic [3:0] P_ONES_RST = 4'(DEFAULT_PILL % 10);
  localparam logic [7:0] BOTTLE_RST = 8'(DEFAULT_BOTTLE);
  localparam logic [7:0] PILL_RST   = 8'(DEFAULT_PILL);

  // Input index: 0 start, 1 select, 2 up, 3 pill sensor.
  localparam int unsigned IDX_UP   = 2;
  localparam int unsigned IDX_PILL = 3;

  logic [3:0]         raw;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         stable_q, stable_d;
  logic [3:0]         stable_dly_q, stable_dly_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [3:0][CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0]      thr;

  logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
  logic               rep_phase_q, rep_phase_d;
  logic               rep_tick;
  logic               inc_evt;

  logic [3:0]         b_tens_q, b_tens_d, b_ones_q, b_ones_d;
  logic [3:0]         p_tens_q, p_tens_d, p_ones_q, p_ones_d;
  logic [7:0]         bottle_q, bottle_d, pill_q, pill_d;

  logic [FW-1:0]      fl_cnt_q, fl_cnt_d;
  logic               flicker_q, flicker_d;
  logic               sel_unused;

  assign raw        = {pill_sensor_raw, key_up_raw, key_select_raw, key_start_raw};
  assign sel_unused = selection[0];

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    pulse_d      = stable_q & ~stable_dly_q;
    db_cnt_d     = '0;
    thr          = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      thr = (i == IDX_PILL) ? CW'(PILL_DEBOUNCE_CYCLES - 1) : CW'(DEBOUNCE_CYCLES - 1);
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == thr) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The counter holds 0 until the cycle the up strobe is visible, so its value equals
  // the cycle offset from the press event; phase 0 waits REPEAT_DELAY, phase 1 REPEAT_PERIOD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_tick    = 1'b0;
    if (!stable_q[IDX_UP]) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (stable_dly_q[IDX_UP]) begin
      if ((!rep_phase_q && rep_cnt_q == RW'(REPEAT_DELAY)) ||
          ( rep_phase_q && rep_cnt_q == RW'(REPEAT_PERIOD))) begin
        rep_tick    = 1'b1;
        rep_cnt_d   = RW'(1);
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  assign inc_evt = (pulse_q[IDX_UP] | rep_tick) & ~working & (|selection[4:1]);

  always_comb begin
    b_tens_d = b_tens_q;
    b_ones_d = b_ones_q;
    p_tens_d = p_tens_q;
    p_ones_d = p_ones_q;
    if (inc_evt) begin
      if (selection[1])      b_ones_d = bcd_inc(b_ones_q);
      else if (selection[2]) b_tens_d = bcd_inc(b_tens_q);
      else if (selection[3]) p_ones_d = bcd_inc(p_ones_q);
      else                   p_tens_d = bcd_inc(p_tens_q);
      if (b_tens_d == 4'd0 && b_ones_d == 4'd0) b_ones_d = 4'd1;
      if (p_tens_d == 4'd0 && p_ones_d == 4'd0) p_ones_d = 4'd1;
    end
    bottle_d = 8'(b_tens_q) * 8'd10 + 8'(b_ones_q);
    pill_d   = 8'(p_tens_q) * 8'd10 + 8'(p_ones_q);
  end

  always_comb begin
    fl_cnt_d  = fl_cnt_q + 1'b1;
    flicker_d = flicker_q;
    if (fl_cnt_q == FW'(FLICKER_HALF - 1)) begin
      fl_cnt_d  = '0;
      flicker_d = ~flicker_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      db_cnt_q     <= '0;
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      b_tens_q     <= B_TENS_RST;
      b_ones_q     <= B_ONES_RST;
      p_tens_q     <= P_TENS_RST;
      p_ones_q     <= P_ONES_RST;
      bottle_q     <= BOTTLE_RST;
      pill_q       <= PILL_RST;
      fl_cnt_q     <= '0;
      flicker_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pulse_q      <= pulse_d;
      db_cnt_q     <= db_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_phase_q  <= rep_phase_d;
      b_tens_q     <= b_tens_d;
      b_ones_q     <= b_ones_d;
      p_tens_q     <= p_tens_d;
      p_ones_q     <= p_ones_d;
      bottle_q     <= bottle_d;
      pill_q       <= pill_d;
      fl_cnt_q     <= fl_cnt_d;
      flicker_q    <= flicker_d;
    end
  end

  assign flip_working    = pulse_q[0];
  assign shift_selection = pulse_q[1];
  assign pill_pulse      = pulse_q[IDX_PILL];
  assign display_flicker = flicker_q;
  assign bottle_setting  = bottle_q;
  assign pill_setting    = pill_q;

endmodule

// File: tb/tb_bottling_input_frontend.sv
// Scoreboard bench for bottling_input_frontend: stimulus pushes expected events
// (kind, value, cycle); a negedge monitor pops them as the DUT presents outputs.
module tb_bottling_input_frontend;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_raw = 1'b0, key_select_raw = 1'b0, key_up_raw = 1'b0;
  logic       pill_sensor_raw = 1'b0, working = 1'b0;
  logic [4:0] selection = 5'b00000;
  logic       flip_working, shift_selection, pill_pulse, display_flicker;
  logic [7:0] bottle_setting, pill_setting;

  bottling_input_frontend #(
    .DEBOUNCE_CYCLES(4),
    .PILL_DEBOUNCE_CYCLES(2),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(5),
    .FLICKER_HALF(3),
    .DEFAULT_BOTTLE(10),
    .DEFAULT_PILL(5)
  ) dut (
    .clk(clk), .reset(reset),
    .key_start_raw(key_start_raw), .key_select_raw(key_select_raw),
    .key_up_raw(key_up_raw), .pill_sensor_raw(pill_sensor_raw),
    .working(working), .selection(selection),
    .flip_working(flip_working), .shift_selection(shift_selection),
    .pill_pulse(pill_pulse), .display_flicker(display_flicker),
    .bottle_setting(bottle_setting), .pill_setting(pill_setting)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 flip_working, 1 shift_selection, 2 pill_pulse, 3 bottle_setting, 4 pill_setting
  typedef struct { int kind; int val; int cyc; } exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic [7:0] prev_b, prev_p;
  int   b;

  function automatic void push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    sb.push_back(e);
  endfunction

  task automatic match(input int kind, input int act, input string name);
    int idx;
    idx = -1;
    checks++;
    foreach (sb[i]) if (idx < 0 && sb[i].kind == kind) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s: unexpected value %0d at cycle %0d, none expected", name, act, cyc);
    end else begin
      if (sb[idx].val != act || (sb[idx].cyc >= 0 && sb[idx].cyc != cyc)) begin
        errors++;
        $display("FAIL %s: got %0d at cycle %0d, expected %0d at cycle %0d",
                 name, act, cyc, sb[idx].val, sb[idx].cyc);
      end
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (flip_working)    match(0, 1, "flip_working");
      if (shift_selection) match(1, 1, "shift_selection");
      if (pill_pulse)      match(2, 1, "pill_pulse");
      if (bottle_setting != prev_b) match(3, int'(bottle_setting), "bottle_setting");
      if (pill_setting   != prev_p) match(4, int'(pill_setting),   "pill_setting");
      prev_b = bottle_setting;
      prev_p = pill_setting;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_key(input int key, input logic v);
    case (key)
      0: key_start_raw   = v;
      1: key_select_raw  = v;
      2: key_up_raw      = v;
      default: pill_sensor_raw = v;
    endcase
  endtask

  // Called at a negedge: raw rises now, is sampled by `hold` edges, then falls.
  task automatic press(input int key, input int hold, input int gap);
    set_key(key, 1'b1);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    set_key(key, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic press_up_expect(input int kind, input int val);
    @(negedge clk);
    b = cyc;
    push(kind, val, b + 9);
    press(2, 12, 10);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_bottle", int'(bottle_setting), 10);
    chk("reset_pill", int'(pill_setting), 5);
    chk("reset_flicker", int'(display_flicker), 0);
    chk("reset_strobes", int'({flip_working, shift_selection, pill_pulse}), 0);
    prev_b = bottle_setting;
    prev_p = pill_setting;
    mon_en = 1'b1;

    // Single start press: strobe in the cycle following edge 6; release silent.
    @(negedge clk);
    b = cyc;
    push(0, 1, b + 7);
    press(0, 12, 12);

    // Select glitches (3 high, 1 low) x5 never accepted.
    @(negedge clk);
    repeat (5) begin
      key_select_raw = 1'b1;
      repeat (3) @(negedge clk);
      key_select_raw = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Start and select together: both strobes in the same cycle.
    @(negedge clk);
    b = cyc;
    push(0, 1, b + 7);
    push(1, 1, b + 7);
    key_start_raw = 1'b1; key_select_raw = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    key_start_raw = 1'b0; key_select_raw = 1'b0;
    repeat (12) @(negedge clk);

    // Pill sensor: 1-cycle glitch rejected, then a real drop with N=2.
    @(negedge clk);
    pill_sensor_raw = 1'b1;
    @(negedge clk);
    pill_sensor_raw = 1'b0;
    repeat (8) @(negedge clk);
    b = cyc;
    push(2, 1, b + 5);
    press(3, 8, 8);

    // Bottle ones digit: 10 -> 19, then 9 wraps to 0 without carry.
    selection = 5'b00010;
    for (int v = 11; v <= 19; v++) press_up_expect(3, v);
    press_up_expect(3, 10);
    // Bottle tens digit: 10 -> 90, then 00 forced to 01.
    selection = 5'b00100;
    for (int v = 20; v <= 90; v += 10) press_up_expect(3, v);
    press_up_expect(3, 1);

    // Lockout while working.
    working = 1'b1;
    selection = 5'b00010;
    @(negedge clk);
    press(2, 12, 10);
    chk("lockout_bottle", int'(bottle_setting), 1);
    working = 1'b0;

    // Auto-repeat on pill ones: events at offsets 0, 20, 25, 30, 35.
    selection = 5'b01000;
    @(negedge clk);
    b = cyc;
    push(4, 6, b + 9);
    push(4, 7, b + 29);
    push(4, 8, b + 34);
    push(4, 9, b + 39);
    push(4, 1, b + 44);
    press(2, 39, 20);
    chk("repeat_final_pill", int'(pill_setting), 1);

    // Reset in the middle of a repeat hold.
    @(negedge clk);
    b = cyc;
    push(4, 2, b + 9);
    push(4, 3, b + 29);
    key_up_raw = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    push(3, 10, -1);
    push(4, 5, -1);
    reset = 1'b1;
    key_up_raw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_bottle", int'(bottle_setting), 10);
    chk("midreset_pill", int'(pill_setting), 5);
    chk("midreset_strobes", int'({flip_working, shift_selection, pill_pulse}), 0);
    chk("flicker_0", int'(display_flicker), 0);
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      chk("flicker", int'(display_flicker), (j / 3) % 2);
    end

    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, first kind %0d value %0d cycle %0d",
               sb.size(), sb[0].kind, sb[0].val, sb[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
